// File: rtl/seven_seg_scan.sv
// seven_seg_scan: frame-synchronous 4-digit common-anode scanner with dead-time blanking and 16-level brightness
//   clk, rst        : clock, synchronous active-high reset
//   seg_in[27:0]    : four packed 7-bit active-low digit patterns (digit k at [7k+6:7k])
//   en              : display enable, 0 blanks the outputs
//   bright[3:0]     : brightness, lit in bright of every 16 frames (15 = always)
//   an[3:0]         : active-low anode enables, one low at a time
//   cath[6:0]       : active-low shared cathode bus
//   frame_done      : one-cycle pulse after each frame boundary
module seven_seg_scan #(
  parameter int DIV  = 100000,
  parameter int DEAD = 1000,
  parameter int CW   = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [27:0] seg_in,
  input  logic        en,
  input  logic [3:0]  bright,
  output logic [3:0]  an,
  output logic [6:0]  cath,
  output logic        frame_done
);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    d_q, d_d;
  logic [3:0]    fc_q, bright_q, an_q, an_d;
  logic [27:0]   shadow_q;
  logic [6:0]    cath_q, cath_d;
  logic          frame_done_q, wrap, fb, lit;
  always_comb begin
    wrap   = cnt_q == CW'(DIV - 1);
    fb     = wrap && d_q == 2'd3;
    cnt_d  = wrap ? '0 : cnt_q + 1'b1;
    d_d    = wrap ? d_q + 2'd1 : d_q;
    // frame counter below bright_q gives bright_q lit frames out of 16
    lit    = en && cnt_q >= CW'(DEAD) && (bright_q == 4'hF || fc_q < bright_q);
    an_d   = lit ? ~(4'b0001 << d_q) : 4'hF;
    cath_d = lit ? shadow_q[7*d_q +: 7] : 7'h7F;
  end
  // anode and cathode are registered together so a digit never sees its neighbour's pattern
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      d_q          <= '0;
      fc_q         <= '0;
      shadow_q     <= '1;
      bright_q     <= '0;
      an_q         <= 4'hF;
      cath_q       <= 7'h7F;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      d_q          <= d_d;
      an_q         <= an_d;
      cath_q       <= cath_d;
      frame_done_q <= fb;
      if (fb) begin
        shadow_q <= seg_in;
        bright_q <= bright;
        fc_q     <= fc_q + 4'd1;
      end
    end
  end
  assign an         = an_q;
  assign cath       = cath_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: directed self-checking bench for seven_seg_scan with DIV=8, DEAD=2
module tb_seven_seg_scan;
  logic        clk = 1'b0;
  logic        rst, en, frame_done;
  logic [27:0] seg_in;
  logic [3:0]  bright, an;
  logic [6:0]  cath;
  int          checks = 0, errors = 0, t = 0;
  localparam logic [27:0] P0 = 28'h0000081;
  localparam logic [27:0] P1 = {7'b0010010, 7'b1001111, 7'b0000001, 7'b0000001};
  localparam logic [27:0] P2 = {7'b0000110, 7'b1001100, 7'b0100100, 7'b0110000};
  seven_seg_scan #(.DIV(8), .DEAD(2), .CW(3)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .en(en), .bright(bright),
    .an(an), .cath(cath), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
    t++;
  endtask
  function automatic logic [3:0] ean(input int s, input bit lit);
    return lit ? ~(4'b0001 << ((s / 8) % 4)) : 4'hF;
  endfunction
  function automatic logic [6:0] ecath(input int s, input bit lit, input logic [27:0] p);
    logic [27:0] q;
    q = p >> (7 * ((s / 8) % 4));
    return lit ? q[6:0] : 7'h7F;
  endfunction
  task automatic test_reset;
    bit lit;
    rst = 1'b1; en = 1'b1; bright = 4'd15; seg_in = P0;
    repeat (3) tick();
    checks++;
    if (an !== 4'hF || cath !== 7'h7F || frame_done !== 1'b0) begin
      errors++; $display("FAIL reset_state an=%b cath=%b fd=%b exp 1111 1111111 0", an, cath, frame_done);
    end
    rst = 1'b0; t = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      lit = t > 32 && (t - 1) % 8 >= 2;
      checks++;
      if (an !== ean(t - 1, lit) || cath !== ecath(t - 1, lit, P0)) begin
        errors++; $display("FAIL reset_frames t=%0d an=%b cath=%b exp %b %b", t, an, cath, ean(t - 1, lit), ecath(t - 1, lit, P0));
      end
      checks++;
      if (frame_done !== (t % 32 == 0)) begin
        errors++; $display("FAIL reset_frame_done t=%0d got %b exp %b", t, frame_done, t % 32 == 0);
      end
    end
  endtask
  task automatic test_digit_map;
    bit lit;
    seg_in = P1;
    for (int i = 0; i < 64; i++) begin
      tick();
      lit = (t - 1) % 8 >= 2;
      checks++;
      if (an !== ean(t - 1, lit) || cath !== ecath(t - 1, lit, t > 96 ? P1 : P0)) begin
        errors++; $display("FAIL digit_map t=%0d an=%b cath=%b exp %b %b", t, an, cath, ean(t - 1, lit), ecath(t - 1, lit, t > 96 ? P1 : P0));
      end
      checks++;
      if ($countones(~an) > 1) begin
        errors++; $display("FAIL digit_map_onehot t=%0d an=%b exp at most one low", t, an);
      end
    end
  endtask
  task automatic test_capture;
    bit lit;
    repeat (11) tick();
    seg_in = P2;
    for (int i = 0; i < 53; i++) begin
      tick();
      lit = (t - 1) % 8 >= 2;
      checks++;
      if (an !== ean(t - 1, lit) || cath !== ecath(t - 1, lit, t > 160 ? P2 : P1)) begin
        errors++; $display("FAIL capture t=%0d an=%b cath=%b exp %b %b", t, an, cath, ean(t - 1, lit), ecath(t - 1, lit, t > 160 ? P2 : P1));
      end
    end
  endtask
  task automatic test_bright;
    bit lit;
    int eb, fc;
    eb = 15;
    for (int f = 0; f < 23; f++) begin
      bright = f < 20 ? 4'd4 : (f == 20 ? 4'd0 : 4'd15);
      for (int i = 0; i < 32; i++) begin
        tick();
        fc = ((t - 1) / 32) % 16;
        lit = (t - 1) % 8 >= 2 && (eb == 15 || fc < eb);
        checks++;
        if (an !== ean(t - 1, lit) || cath !== ecath(t - 1, lit, P2)) begin
          errors++; $display("FAIL bright t=%0d fc=%0d bq=%0d an=%b cath=%b exp %b %b", t, fc, eb, an, cath, ean(t - 1, lit), ecath(t - 1, lit, P2));
        end
      end
      eb = f < 20 ? 4 : (f == 20 ? 0 : 15);
    end
  endtask
  task automatic test_enable;
    bit lit;
    repeat (4) tick();
    checks++;
    if (an !== 4'b1110 || cath !== 7'b0110000) begin
      errors++; $display("FAIL enable_pre an=%b cath=%b exp 1110 0110000", an, cath);
    end
    en = 1'b0;
    for (int i = 0; i < 28; i++) begin
      tick();
      checks++;
      if (an !== 4'hF || cath !== 7'h7F || frame_done !== (t % 32 == 0)) begin
        errors++; $display("FAIL enable_off t=%0d an=%b cath=%b fd=%b exp 1111 1111111 %b", t, an, cath, frame_done, t % 32 == 0);
      end
    end
    en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick();
      lit = (t - 1) % 8 >= 2;
      checks++;
      if (an !== ean(t - 1, lit) || cath !== ecath(t - 1, lit, P2) || frame_done !== (t % 32 == 0)) begin
        errors++; $display("FAIL enable_on t=%0d an=%b cath=%b fd=%b exp %b %b", t, an, cath, frame_done, ean(t - 1, lit), ecath(t - 1, lit, P2));
      end
    end
  endtask
  task automatic test_reset_mid;
    bit lit;
    repeat (21) tick();
    checks++;
    if (an !== 4'b1011 || cath !== 7'b1001100) begin
      errors++; $display("FAIL reset_mid_pre an=%b cath=%b exp 1011 1001100", an, cath);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (an !== 4'hF || cath !== 7'h7F || frame_done !== 1'b0) begin
      errors++; $display("FAIL reset_mid an=%b cath=%b fd=%b exp 1111 1111111 0", an, cath, frame_done);
    end
    rst = 1'b0; t = 0;
    for (int i = 0; i < 44; i++) begin
      tick();
      lit = t > 32 && (t - 1) % 8 >= 2;
      checks++;
      if (an !== ean(t - 1, lit) || cath !== ecath(t - 1, lit, P2) || frame_done !== (t == 32)) begin
        errors++; $display("FAIL reset_mid_after t=%0d an=%b cath=%b fd=%b exp %b %b %b", t, an, cath, frame_done, ean(t - 1, lit), ecath(t - 1, lit, P2), t == 32);
      end
    end
  endtask
  initial begin
    test_reset();
    test_digit_map();
    test_capture();
    test_bright();
    test_enable();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
- Physical-display end of the 28-bit seven-segment bus produced by the vending machine's value-to-segment encoder.
- Takes the four packed 7-bit digit patterns and time-multiplexes them onto a 4-digit common-anode LED display.
  - One digit is driven at a time, with active-low anode enables and a shared active-low cathode bus.
- Provides frame-synchronous latching (no tearing), a dead-time blanking interval per digit (anti-ghosting) and 16-level frame-based brightness control.

Parameters:
- DIV, 100000, clocks per digit slot (must be ≥2).
- DEAD, 1000, blank clocks at the start of each slot (must be < DIV).
- CW, 17, prescaler counter width (must satisfy 2^CW ≥ DIV).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- seg_in  in  28  packed digit patterns.
  - Digit k = seg_in[7k+6:7k], bit6=a … bit0=g, active-low (0 = segment lit).
  - Example: "0" = 7'b0000001.
- en  in  1  display enable; 0 forces blank outputs.
- bright  in  4  brightness level; 0 = dark, 15 = always on.
- an  out  4  anode enables, active-low; an[k] drives digit k.
- cath  out  7  cathode pattern, active-low, same bit order as seg_in.
- frame_done  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset (rst=1 at clk edge), all cleared on that edge, including mid-frame:
  - cnt=0, slot d=0, frame counter fc=0.
  - shadow=28'hFFFFFFF (all segments off), bright_q=0.
  - an=4'b1111, cath=7'h7F, frame_done=0.
- Prescaler:
  - cnt counts 0..DIV-1 and wraps to 0.
  - When cnt==DIV-1, d advances 0→1→2→3→0.
- Frame boundary (fb) is the condition cnt==DIV-1 && d==3. On the edge where fb holds:
  - shadow ← seg_in.
  - bright_q ← bright.
  - fc ← fc+1 (4-bit, wraps 15→0).
- seg_in and bright changes at any other time have no visible effect until the next fb.
- Lit condition, evaluated on current state before the edge:
  - lit = en && (cnt ≥ DEAD) && (bright_q==15 || fc < bright_q).
- Registered outputs, 1-cycle latency from counter state:
  - lit=1: an = ~(4'b0001 << d); cath = shadow[7d+6:7d].
  - lit=0: an=4'b1111; cath=7'h7F.
  - At most one an bit is low in any cycle.
  - an and cath change only together: no cycle has an anode low with the previous digit's cathodes.
- frame_done: registered; equals 1 for exactly the one cycle following an fb edge.
- Brightness: digit lit in bright_q out of every 16 frames (15 → 16 of 16). bright_q=0 → permanently dark while counters keep running.
- en:
  - Acts combinationally into the output register, so en=0 blanks outputs on the next edge.
  - Counters, fc and shadow capture continue regardless of en.
- First frame after reset displays blank (shadow all ones, bright_q=0). The input becomes visible from the second frame.
- Frame period = 4·DIV clocks; digit on-time per slot = DIV−DEAD clocks.
- Out-of-range patterns are passed through unmodified; no decoding or validation is performed.

Test Plan (DIV=8, DEAD=2, CW=3):
1. Reset sequence:
   - Stimulus: rst high 3 cycles, then low; seg_in=28'h0000081 (digit0="0", digit1="0"), bright=15, en=1.
   - Required: an=1111 and cath=7F for the whole first frame (32 cycles); frame_done high exactly at cycle 32 after reset release.
   - Required in frame 2: slot0 shows an=1110, cath=0000001 on cnt 2..7 (outputs 1 cycle later) and blank on cnt 0..1; slot1 shows an=1101, cath=0000001.
2. Digit mapping:
   - Stimulus: seg_in digit2=1001111 ("1"), digit3=0010010 ("2").
   - Required in the next full frame: an=1011 with cath=1001111, then an=0111 with cath=0010010; never two an bits low.
3. Frame-synchronous capture:
   - Stimulus: change seg_in during slot1 of a frame.
   - Required: the remainder of that frame shows the old patterns; new patterns appear from slot0 of the following frame.
4. Brightness:
   - Stimulus: bright=4 held for 20 frames.
   - Required: digits lit only in frames with fc ∈ {0,1,2,3}; bright=0 gives an constantly 1111; bright=15 gives lit every frame.
5. Enable and reset mid-operation:
   - Stimulus: drop en mid-slot.
     - Required: an=1111 and cath=7F from the next cycle; counters and frame_done timing unchanged.
   - Stimulus: assert rst at cnt=5, d=2.
     - Required: next cycle an=1111, cath=7F, frame_done=0; counting restarts at d=0, cnt=0; display blank for one frame.
